// File: rtl/quick_spi_ex.sv
// Parametrised full-duplex SPI master with runtime divider, per-transfer mode and burst chip-select
// hold. Define QUICK_SPI_EX_LOOPBACK_EN to add a `loopback` input routing mosi into the receiver.
module quick_spi_ex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned SLAVES     = 4,
    parameter int unsigned DIV_WIDTH  = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned SEL_WIDTH  = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    output logic                  busy,
    input  logic [SEL_WIDTH-1:0]  slave_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic                  keep_ss,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  sclk,
    output logic                  mosi,
`ifdef QUICK_SPI_EX_LOOPBACK_EN
    input  logic                  loopback,
`endif
    input  logic                  miso,
    output logic [SLAVES-1:0]     ss_n
);

    localparam int unsigned NEdges = 2 * DATA_WIDTH;
    localparam int unsigned EdgeW  = $clog2(NEdges + 1);

    typedef enum logic [1:0] {StIdle, StLinger, StShift, StHold} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [EdgeW-1:0]      edge_q, edge_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rxsh_q, rxsh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [SLAVES-1:0]     ss_n_q, ss_n_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  keep_q, keep_d;
    logic                  rx_in;
    logic                  lead, last, do_sample, do_shift;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                        input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
    endfunction

    // Out-of-range indices match no line, leaving every select deasserted.
    function automatic logic [SLAVES-1:0] decode_sel(input logic [SEL_WIDTH-1:0] sel);
        logic [SLAVES-1:0] dec;
        dec = '1;
        for (int i = 0; i < int'(SLAVES); i++) begin
            dec[i] = (sel != SEL_WIDTH'(i));
        end
        return dec;
    endfunction

`ifdef QUICK_SPI_EX_LOOPBACK_EN
    assign rx_in = loopback ? mosi_q : miso;
`else
    assign rx_in = miso;
`endif

    // edge_q counts toggles already made, so an even count means the next edge is leading.
    assign lead      = ~edge_q[0];
    assign last      = (edge_q == EdgeW'(NEdges - 1));
    assign do_sample = cpha_q ? ~lead : lead;
    assign do_shift  = cpha_q ? lead : (~lead & ~last);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rxsh_d     = rxsh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        keep_d     = keep_q;
        unique case (state_q)
            StIdle, StLinger: begin
                if (start) begin
                    state_d = StShift;
                    cnt_d   = clk_div;
                    div_d   = clk_div;
                    edge_d  = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    keep_d  = keep_ss;
                    if (cpha) begin
                        tx_d = tx_data;
                    end else begin
                        mosi_d = first_bit(tx_data);
                        tx_d   = shift_out(tx_data);
                    end
                    // A held select keeps its slave and clock level across the burst.
                    if (state_q == StIdle) begin
                        sclk_d = cpol;
                        ss_n_d = decode_sel(slave_sel);
                    end
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    cnt_d  = div_q;
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EdgeW'(1);
                    if (do_sample) begin
                        rxsh_d = shift_in(rxsh_q, rx_in);
                    end
                    if (do_shift) begin
                        mosi_d = first_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end
                    if (last) begin
                        state_d = StHold;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rxsh_q;
                    if (keep_q) begin
                        state_d = StLinger;
                    end else begin
                        state_d = StIdle;
                        ss_n_d  = '1;
                        mosi_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            keep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            keep_q     <= keep_d;
        end
    end

    assign ready    = (state_q == StIdle) || (state_q == StLinger);
    assign busy     = ~ready;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_quick_spi_ex.sv
// Directed bench for quick_spi_ex: cycle-accurate slave stimulus with hand-derived expectations.
module tb_quick_spi_ex;

    logic       clk = 1'b0;
    logic       reset, start, cpol, cpha, keep_ss, miso;
    logic [2:0] slave_sel;
    logic [7:0] clk_div, tx_data, rx_data;
    logic       ready, busy, rx_valid, sclk, mosi;
    logic [3:0] ss_n;
`ifdef QUICK_SPI_EX_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    quick_spi_ex #(
        .DATA_WIDTH(8),
        .SLAVES    (4),
        .DIV_WIDTH (8),
        .MSB_FIRST (1),
        .SEL_WIDTH (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .slave_sel(slave_sel),
        .cpol     (cpol),
        .cpha     (cpha),
        .clk_div  (clk_div),
        .keep_ss  (keep_ss),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .sclk     (sclk),
        .mosi     (mosi),
`ifdef QUICK_SPI_EX_LOOPBACK_EN
        .loopback (loopback),
`endif
        .miso     (miso),
        .ss_n     (ss_n)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge (cycle 0); returns at the negedge of the rx_valid cycle.
    task automatic do_xfer(input string tag, input logic [7:0] tx, input logic [7:0] slv,
                           input logic [2:0] sel, input logic pol, input logic pha,
                           input logic [7:0] div, input logic keep, input logic [3:0] exp_ss,
                           input int poke_c, input bit miso_zero, input logic [7:0] exp_rx);
        int h, last_c, edges, k, j, smp;
        int ss_bad, sclk_bad, mosi_bad, early_bad;
        logic sclk_exp;
        ss_bad = 0; sclk_bad = 0; mosi_bad = 0; early_bad = 0;
        h      = int'(div) + 1;
        last_c = 1 + 17 * h;
        start     = 1'b1;
        tx_data   = tx;
        slave_sel = sel;
        cpol      = pol;
        cpha      = pha;
        clk_div   = div;
        keep_ss   = keep;
        miso      = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            start = (c == poke_c);
            if (c == poke_c) tx_data = ~tx;
            edges = (c - 1) / h;
            if (edges > 16) edges = 16;
            smp  = pha ? edges / 2 : (edges + 1) / 2;
            miso = (miso_zero || smp > 7) ? 1'b0 : slv[7 - smp];
            if (c < last_c) begin
                sclk_exp = pol ^ edges[0];
                if (ss_n !== exp_ss) ss_bad++;
                if (sclk !== sclk_exp) sclk_bad++;
                if (rx_valid !== 1'b0 || ready !== 1'b0) early_bad++;
                if (c % h == 0) begin
                    k = c / h;
                    if (k <= 16 && ((k % 2 == 1) != pha)) begin
                        j = (k - 1) / 2;
                        if (mosi !== tx[7 - j]) mosi_bad++;
                    end
                end
            end
        end
        check_eq({tag, " ss_n during transfer"}, ss_bad, 0);
        check_eq({tag, " sclk waveform"}, sclk_bad, 0);
        check_eq({tag, " mosi at sample edges"}, mosi_bad, 0);
        check_eq({tag, " no early rx_valid/ready"}, early_bad, 0);
        check_eq({tag, " rx_valid at end"}, rx_valid, 1);
        check_eq({tag, " rx_data"}, rx_data, exp_rx);
        check_eq({tag, " ready at end"}, ready, 1);
        check_eq({tag, " ss_n at end"}, ss_n, keep ? exp_ss : 4'hF);
        check_eq({tag, " sclk idle"}, sclk, pol);
        if (!keep) check_eq({tag, " mosi idle"}, mosi, 0);
    endtask

    initial begin
        int extra;
        reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; keep_ss = 1'b0; miso = 1'b0;
        slave_sel = '0; clk_div = '0; tx_data = '0;
        repeat (3) @(negedge clk);
        check_eq("reset ready", ready, 1);
        check_eq("reset busy", busy, 0);
        check_eq("reset rx_valid", rx_valid, 0);
        check_eq("reset rx_data", rx_data, 0);
        check_eq("reset sclk", sclk, 0);
        check_eq("reset mosi", mosi, 0);
        check_eq("reset ss_n", ss_n, 4'hF);
        reset = 1'b0;
        @(negedge clk);

        do_xfer("mode0", 8'hA5, 8'h3C, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0, 4'b1101, 0, 1'b0, 8'h3C);
        @(negedge clk);
        check_eq("mode0 rx_valid one cycle", rx_valid, 0);
        check_eq("mode0 rx_data stable", rx_data, 8'h3C);

        do_xfer("mode3", 8'h81, 8'hF0, 3'd0, 1'b1, 1'b1, 8'd0, 1'b0, 4'b1110, 0, 1'b0, 8'hF0);
        @(negedge clk);
        check_eq("mode3 sclk idles high", sclk, 1);

        do_xfer("mode1", 8'h3C, 8'hC5, 3'd3, 1'b0, 1'b1, 8'd2, 1'b0, 4'b0111, 0, 1'b0, 8'hC5);
        @(negedge clk);

        do_xfer("burst0", 8'h12, 8'h55, 3'd2, 1'b0, 1'b0, 8'd1, 1'b1, 4'b1011, 0, 1'b0, 8'h55);
        do_xfer("burst1", 8'h34, 8'hAA, 3'd0, 1'b0, 1'b0, 8'd1, 1'b0, 4'b1011, 0, 1'b0, 8'hAA);
        @(negedge clk);
        check_eq("burst ss_n released", ss_n, 4'hF);

        do_xfer("poke", 8'hC3, 8'h5A, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0, 4'b1101, 9, 1'b0, 8'h5A);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rx_valid === 1'b1 || busy !== 1'b0) extra++;
        end
        check_eq("poke single rx_valid", extra, 0);

        do_xfer("sel5", 8'h0F, 8'h99, 3'd5, 1'b0, 1'b0, 8'd1, 1'b0, 4'hF, 0, 1'b0, 8'h99);
        @(negedge clk);

        // Reset landing once edge 5 is visible (cycle 11 with H=2).
        start = 1'b1; tx_data = 8'hA5; slave_sel = 3'd1; cpol = 1'b0; cpha = 1'b0;
        clk_div = 8'd1; keep_ss = 1'b0; miso = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("rst pre sclk at edge5", sclk, 1);
        check_eq("rst pre ss_n", ss_n, 4'b1101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst ss_n", ss_n, 4'hF);
        check_eq("rst sclk", sclk, 0);
        check_eq("rst ready", ready, 1);
        check_eq("rst rx_valid", rx_valid, 0);
        check_eq("rst rx_data cleared", rx_data, 0);
        extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) extra++;
        end
        check_eq("rst no rx_valid after", extra, 0);

`ifdef QUICK_SPI_EX_LOOPBACK_EN
        loopback = 1'b1;
        do_xfer("loop", 8'h5A, 8'hFF, 3'd1, 1'b0, 1'b0, 8'd1, 1'b0, 4'b1101, 0, 1'b1, 8'h5A);
        loopback = 1'b0;
        @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
